// File: rtl/fx_kport_if.sv
//------------------------------------------------------------------------------
// fx_kport_if
// Bundle of the signals between one K-port engine, its gate-array host side
// and the controller pad pins.
//   Host side : TRG, MOD, IOS, TXD, KD_RD (to engine); KD, END, BUSY (from engine)
//   Pad side  : KP_DIN (to engine); KP_LATCH, KP_CLK, KP_DOUT (from engine)
// Modports:
//   slave  - the engine (fx_kport)
//   master - whatever drives the host requests and models the pad
//------------------------------------------------------------------------------
interface fx_kport_if;
    logic        TRG;
    logic        MOD;
    logic        IOS;
    logic [31:0] TXD;
    logic        KD_RD;
    logic [31:0] KD;
    logic        END;
    logic        BUSY;
    logic        KP_LATCH;
    logic        KP_CLK;
    logic        KP_DOUT;
    logic        KP_DIN;

    modport slave (
        input  TRG, MOD, IOS, TXD, KD_RD, KP_DIN,
        output KD, END, BUSY, KP_LATCH, KP_CLK, KP_DOUT
    );

    modport master (
        output TRG, MOD, IOS, TXD, KD_RD, KP_DIN,
        input  KD, END, BUSY, KP_LATCH, KP_CLK, KP_DOUT
    );
endinterface

// File: rtl/fx_kport.sv
//------------------------------------------------------------------------------
// fx_kport
// Serial K-port (keypad) engine for one PC-FX controller port. A trigger runs
// one 32-bit transfer on the pad pins: an optional latch pulse, then 32 bits
// clocked LSB first. The received word and an end flag are then presented to
// the gate-array KPC registers.
// Parameters:
//   DIV  - CE cycles per half bit period and latch pulse length (1..255)
// Ports:
//   CLK  - system clock
//   RESn - asynchronous active-low reset
//   CE   - clock enable; all state advances only on CE cycles
//   kp   - host and pad signals (fx_kport_if.slave)
//------------------------------------------------------------------------------
module fx_kport #(
    parameter int unsigned DIV = 4
) (
    input  logic       CLK,
    input  logic       RESn,
    input  logic       CE,
    fx_kport_if.slave  kp
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_SHIFT_LO = 3'd2;
    localparam logic [2:0] S_SHIFT_HI = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    // Phase counter reload: counts DIV-1 down to 0.
    localparam logic [7:0] PH_LOAD = 8'(DIV - 1);

    logic [2:0]  state;
    logic [7:0]  phase_cnt;
    logic [4:0]  bit_idx;
    logic        ios_r;
    logic [31:0] shreg;     // TXD on transmit, assembled word on receive
    logic [31:0] kd_r;
    logic        end_r;
    logic        busy_r;
    logic        latch_r;
    logic        kclk_r;
    logic        dout_r;

    // Pad outputs and flags are registered together with the state they
    // describe, so each output changes on the same CE edge as the state.
    // NOTE: every register here uses non-blocking assignment so all of them
    // see pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge CLK or negedge RESn) begin
        // NOTE: the shift register is reset as well, so an aborted transfer
        // leaves no partial word behind.
        if (!RESn) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            bit_idx   <= '0;
            ios_r     <= 1'b0;
            shreg     <= '0;
            kd_r      <= '0;
            end_r     <= 1'b0;
            busy_r    <= 1'b0;
            latch_r   <= 1'b0;
            kclk_r    <= 1'b1;
            dout_r    <= 1'b1;
        end else if (CE) begin
            if (kp.KD_RD)
                end_r <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (kp.TRG) begin
                        ios_r     <= kp.IOS;
                        shreg     <= kp.TXD;
                        busy_r    <= 1'b1;
                        end_r     <= 1'b0;
                        bit_idx   <= '0;
                        phase_cnt <= PH_LOAD;
                        if (kp.MOD) begin
                            state   <= S_LATCH;
                            latch_r <= 1'b1;
                        end else begin
                            state  <= S_SHIFT_LO;
                            kclk_r <= 1'b0;
                            dout_r <= kp.IOS ? 1'b1 : kp.TXD[0];
                        end
                    end
                end

                S_LATCH: begin
                    if (phase_cnt == 8'd0) begin
                        state     <= S_SHIFT_LO;
                        phase_cnt <= PH_LOAD;
                        latch_r   <= 1'b0;
                        kclk_r    <= 1'b0;
                        dout_r    <= ios_r ? 1'b1 : shreg[0];
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_SHIFT_LO: begin
                    if (phase_cnt == 8'd0) begin
                        // Sample coincides with the KP_CLK rising edge.
                        if (ios_r)
                            shreg[bit_idx] <= kp.KP_DIN;
                        state     <= S_SHIFT_HI;
                        phase_cnt <= PH_LOAD;
                        kclk_r    <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_SHIFT_HI: begin
                    if (phase_cnt == 8'd0) begin
                        if (bit_idx == 5'd31) begin
                            state  <= S_DONE;
                            busy_r <= 1'b0;
                            dout_r <= 1'b1;
                            // NOTE: this assignment comes after the KD_RD
                            // clear above, so the set wins on a collision.
                            end_r  <= 1'b1;
                            if (ios_r)
                                kd_r <= shreg;
                        end else begin
                            state     <= S_SHIFT_LO;
                            phase_cnt <= PH_LOAD;
                            bit_idx   <= bit_idx + 5'd1;
                            kclk_r    <= 1'b0;
                            dout_r    <= ios_r ? 1'b1 : shreg[bit_idx + 5'd1];
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign kp.KD       = kd_r;
    assign kp.END      = end_r;
    assign kp.BUSY     = busy_r;
    assign kp.KP_LATCH = latch_r;
    assign kp.KP_CLK   = kclk_r;
    assign kp.KP_DOUT  = dout_r;

endmodule

// File: tb/tb_fx_kport.sv
//------------------------------------------------------------------------------
// tb_fx_kport
// Directed bench for fx_kport. Two engines (DIV=4 and DIV=1) share clock,
// CE and reset; sel picks which one a transfer targets and observes.
// Cycle c holds the values registered by CE edge c-1; TRG is taken on edge 0.
//------------------------------------------------------------------------------
module tb_fx_kport;

    logic        CLK   = 1'b0;
    logic        RESn  = 1'b0;
    logic        CE    = 1'b1;
    logic        trg4  = 1'b0;
    logic        trg1  = 1'b0;
    logic        mod_i = 1'b0;
    logic        ios_i = 1'b0;
    logic        kd_rd = 1'b0;
    logic        kp_din = 1'b0;
    logic [31:0] txd   = '0;
    int          sel   = 4;

    always #5 CLK = ~CLK;

    fx_kport_if if4 ();
    fx_kport_if if1 ();

    assign if4.TRG    = trg4;
    assign if4.MOD    = mod_i;
    assign if4.IOS    = ios_i;
    assign if4.TXD    = txd;
    assign if4.KD_RD  = kd_rd;
    assign if4.KP_DIN = kp_din;
    assign if1.TRG    = trg1;
    assign if1.MOD    = mod_i;
    assign if1.IOS    = ios_i;
    assign if1.TXD    = txd;
    assign if1.KD_RD  = kd_rd;
    assign if1.KP_DIN = kp_din;

    fx_kport #(.DIV(4)) u_dut4 (.CLK(CLK), .RESn(RESn), .CE(CE), .kp(if4.slave));
    fx_kport #(.DIV(1)) u_dut1 (.CLK(CLK), .RESn(RESn), .CE(CE), .kp(if1.slave));

    logic [31:0] o_kd;
    logic        o_end, o_busy, o_latch, o_clk, o_dout;
    assign o_kd    = (sel == 1) ? if1.KD       : if4.KD;
    assign o_end   = (sel == 1) ? if1.END      : if4.END;
    assign o_busy  = (sel == 1) ? if1.BUSY     : if4.BUSY;
    assign o_latch = (sel == 1) ? if1.KP_LATCH : if4.KP_LATCH;
    assign o_clk   = (sel == 1) ? if1.KP_CLK   : if4.KP_CLK;
    assign o_dout  = (sel == 1) ? if1.KP_DOUT  : if4.KP_DOUT;

    int checks   = 0;
    int failures = 0;

    // Per-cycle history of the selected engine during the last run.
    logic [31:0] kd_h    [0:299];
    logic        end_h   [0:299];
    logic        busy_h  [0:299];
    logic        latch_h [0:299];
    logic        clk_h   [0:299];
    logic        dout_h  [0:299];
    int          pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_trg(input logic v);
        if (sel == 1) trg1 = v;
        else          trg4 = v;
    endtask

    // Start a transfer, then record ncyc cycles while modelling the pad:
    // on each KP_CLK falling edge the pad presents the next bit of pad_w.
    task automatic run(input logic m, input logic io, input logic [31:0] tx,
                       input logic [31:0] pad_w, input int ncyc,
                       input bit retrig, input int rd_at);
        int   k;
        logic prev;
        mod_i = m;
        ios_i = io;
        txd   = tx;
        set_trg(1'b1);
        tick();
        set_trg(1'b0);
        pulses = 0;
        k      = -1;
        prev   = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            kd_h[c]    = o_kd;
            end_h[c]   = o_end;
            busy_h[c]  = o_busy;
            latch_h[c] = o_latch;
            clk_h[c]   = o_clk;
            dout_h[c]  = o_dout;
            if (o_clk == 1'b0 && prev == 1'b1) begin
                pulses++;
                k++;
            end
            prev = o_clk;
            if (k >= 0 && k < 32)
                kp_din = pad_w[k];
            set_trg(retrig && (c == 10 || c == 100));
            kd_rd = (c == rd_at);
            tick();
        end
        set_trg(1'b0);
        kd_rd = 1'b0;
    endtask

    function automatic int end_rise(input int n);
        for (int c = 2; c <= n; c++)
            if (end_h[c] === 1'b1 && end_h[c-1] === 1'b0)
                return c;
        return -1;
    endfunction

    function automatic int latch_count(input int n);
        int cnt = 0;
        for (int c = 1; c <= n; c++)
            if (latch_h[c] === 1'b1) cnt++;
        return cnt;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        logic [31:0] tx_w;

        // Reset state
        #12;
        check("rst_kd",    o_kd,    32'h0);
        check("rst_end",   o_end,   1'b0);
        check("rst_busy",  o_busy,  1'b0);
        check("rst_latch", o_latch, 1'b0);
        check("rst_kclk",  o_clk,   1'b1);
        check("rst_dout",  o_dout,  1'b1);
        @(negedge CLK);
        RESn = 1'b1;
        tick();

        // Receive, DIV=4, MOD=1; KD_RD on the edge that sets END
        sel = 4;
        run(1'b1, 1'b1, 32'h0, 32'hA5C3_0F01, 270, 1'b0, 260);
        check("rx_busy_start",   busy_h[1],       1'b1);
        check("rx_latch_c1",     latch_h[1],      1'b1);
        check("rx_latch_c4",     latch_h[4],      1'b1);
        check("rx_latch_c5",     latch_h[5],      1'b0);
        check("rx_latch_len",    latch_count(270), 4);
        check("rx_kclk_c4",      clk_h[4],        1'b1);
        check("rx_bit0_low",     clk_h[5],        1'b0);
        check("rx_bit31_prev",   clk_h[252],      1'b1);
        check("rx_bit31_low",    clk_h[253],      1'b0);
        check("rx_pulses",       pulses,          32);
        check("rx_kd_partial",   kd_h[260],       32'h0);
        check("rx_end_cycle",    end_rise(270),   261);
        check("rx_kd",           kd_h[261],       32'hA5C3_0F01);
        check("rx_busy_end",     busy_h[261],     1'b0);
        check("rx_rd_set_wins",  end_h[262],      1'b1);

        // Transmit, MOD=0; END from the previous run is cleared by TRG
        tx_w = 32'h8000_0001;
        run(1'b0, 1'b0, tx_w, 32'hFFFF_FFFF, 262, 1'b0, -1);
        check("tx_end_cleared",  end_h[1],        1'b0);
        check("tx_no_latch",     latch_count(262), 0);
        errs = 0;
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < 4; j++)
                if (clk_h[1 + 8*k + j] !== 1'b0 || dout_h[1 + 8*k + j] !== tx_w[k])
                    errs++;
        check("tx_dout_phases",  errs,            0);
        check("tx_dout_bit0",    dout_h[1],       1'b1);
        check("tx_dout_bit1",    dout_h[9],       1'b0);
        check("tx_dout_bit31",   dout_h[249],     1'b1);
        check("tx_end_cycle",    end_rise(262),   257);
        check("tx_kd_kept",      kd_h[262],       32'hA5C3_0F01);

        // KD_RD one cycle after END is visible clears it on the next cycle
        check("rd_end_held",     o_end,           1'b1);
        kd_rd = 1'b1;
        tick();
        kd_rd = 1'b0;
        check("rd_end_clear",    o_end,           1'b0);

        // Retriggers at cycles 10 and 100 are ignored
        run(1'b1, 1'b1, 32'h0, 32'h1234_5678, 265, 1'b1, -1);
        check("retrig_latch",    latch_count(265), 4);
        check("retrig_pulses",   pulses,          32);
        check("retrig_end",      end_rise(265),   261);
        check("retrig_kd",       kd_h[265],       32'h1234_5678);

        // Reset in the middle of a receive
        run(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 129, 1'b0, -1);
        check("mid_busy",        o_busy,          1'b1);
        RESn = 1'b0;
        #1;
        check("mid_rst_kclk",    o_clk,           1'b1);
        check("mid_rst_latch",   o_latch,         1'b0);
        check("mid_rst_busy",    o_busy,          1'b0);
        check("mid_rst_end",     o_end,           1'b0);
        check("mid_rst_kd",      o_kd,            32'h0);
        @(negedge CLK);
        RESn = 1'b1;
        tick();
        run(1'b0, 1'b1, 32'h0, 32'h0F0F_00FF, 260, 1'b0, -1);
        check("post_rst_end",    end_rise(260),   257);
        check("post_rst_kd",     kd_h[260],       32'h0F0F_00FF);

        // CE low freezes the engine: a TRG seen only while CE=0 does nothing
        CE = 1'b0;
        set_trg(1'b1);
        tick();
        tick();
        set_trg(1'b0);
        CE = 1'b1;
        tick();
        check("ce_gated_trg",    o_busy,          1'b0);

        // DIV=1, MOD=1
        sel = 1;
        run(1'b1, 1'b1, 32'h0, 32'h5A5A_5A5A, 70, 1'b0, -1);
        check("div1_latch_len",  latch_count(70), 1);
        check("div1_latch_c1",   latch_h[1],      1'b1);
        check("div1_kclk_c2",    clk_h[2],        1'b0);
        check("div1_kclk_c3",    clk_h[3],        1'b1);
        check("div1_kclk_c4",    clk_h[4],        1'b0);
        check("div1_pulses",     pulses,          32);
        check("div1_end",        end_rise(70),    66);
        check("div1_busy_end",   busy_h[66],      1'b0);
        check("div1_kd",         kd_h[67],        32'h5A5A_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fx_kport.md
# fx_kport

Serial K-port (keypad) engine for one PC-FX controller port. It sits directly upstream of the gate-array KPC registers. On a trigger it runs one 32-bit serial transfer on the pad pins: an optional latch pulse, then 32 clocked bits. It then presents the received word and an end flag, which the gate array shows as KEND and clears on a data-register read. Two instances are used, one per port.

## Interface
Parameters:
- DIV, default 4: CE cycles per half bit period; also the length of the latch pulse. Legal range 1..255.

Ports:
- CLK  in  1  system clock.
- RESn  in  1  reset, asynchronous, active-low.
- CE  in  1  clock enable. All state advances only on CLK edges with CE=1.
- TRG  in  1  start-transfer pulse, from a KPC trigger write.
- MOD  in  1  1 = issue the latch pulse before shifting; 0 = shift only. Sampled at start.
- IOS  in  1  1 = receive (pad to host); 0 = transmit (host to pad). Sampled at start.
- TXD  in  32  transmit word. Captured at start.
- KD_RD  in  1  pulse on a read of the KPC data register; clears END.
- KD  out  32  last received word.
- END  out  1  transfer complete, data valid.
- BUSY  out  1  transfer in progress. Drives the KPC KTRG readback.
- KP_LATCH  out  1  pad latch, active high.
- KP_CLK  out  1  pad shift clock, idles high.
- KP_DOUT  out  1  serial data to pad.
- KP_DIN  in  1  serial data from pad.

## Operation
- Reset values: KD=0, END=0, BUSY=0, KP_LATCH=0, KP_CLK=1, KP_DOUT=1, state IDLE, counters 0. Reset takes effect immediately, including in the middle of a transfer; no partial word is retained.
- States: IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - On TRG, capture MOD, IOS and TXD into a shift register; set BUSY=1 and END=0.
  - Go to LATCH if MOD=1, else SHIFT_LO. Bit index = 0.
- LATCH: KP_LATCH=1 for DIV CE cycles, then go to SHIFT_LO.
- SHIFT_LO:
  - KP_CLK=0 for DIV CE cycles.
  - If IOS=0, KP_DOUT = TXD bit[index]; if IOS=1, KP_DOUT=1.
  - On the last CE cycle of the phase, if IOS=1, sample KP_DIN into bit[index] (LSB first).
  - Then go to SHIFT_HI.
- SHIFT_HI: KP_CLK=1 for DIV CE cycles. Then, if index=31, go to DONE; else index+1 and go to SHIFT_LO.
- DONE (one CE cycle):
  - If IOS=1, KD takes the assembled word; if IOS=0, KD is unchanged.
  - END=1, BUSY=0, go to IDLE.
- During a transfer KD holds its previous value; it never shows a partial word.
- END is cleared by KD_RD or by a new TRG. If KD_RD arrives on the same CE cycle that DONE sets END, set wins.
- TRG while BUSY=1 is ignored; the transfer in progress is unaffected.
- Counters: the phase counter is 8 bits and counts DIV-1 down to 0. The bit index is 5 bits with no wrap past 31.

## Timing
- Count CE cycles only; TRG is registered on CE cycle 0.
- MOD=1: KP_LATCH high on cycles 1..DIV. The bit k low phase starts at DIV+1+2k·DIV. END rises at cycle 65·DIV+1.
- MOD=0: no latch. The bit k low phase starts at 1+2k·DIV. END rises at cycle 64·DIV+1.
- DIV=4 examples: MOD=1, END at cycle 261; MOD=0, END at cycle 257.
- All outputs are registered; there is no combinational path from input to output.
- KP_DIN is sampled on the CE edge that ends the low phase, i.e. coincident with the rising edge of KP_CLK.
- END clears on the CE cycle after KD_RD.

## Test plan
- Receive, DIV=4, MOD=1, IOS=1, pad model shifting 0xA5C3_0F01 LSB first -> latch high on cycles 1..4, 32 KP_CLK low pulses, KD=0xA5C30F01 and END=1 at cycle 261, BUSY=0.
- Transmit, MOD=0, IOS=0, TXD=0x8000_0001 -> KP_DOUT=1 during bit 0 and bit 31 low phases and 0 during the other low phases, no latch pulse, END at cycle 257, KD unchanged.
- TRG pulses at cycles 10 and 100 of a running transfer -> no restart, END timing identical to a single-trigger run.
- KD_RD on the exact cycle END sets -> END=1. KD_RD one cycle later -> END=0 on the following cycle.
- RESn low at cycle 130 of a receive -> immediately KP_CLK=1, KP_LATCH=0, BUSY=0, END=0, KD=0. A new TRG after reset release completes normally.
- DIV=1, MOD=1 -> KP_LATCH high for 1 cycle, KP_CLK toggles every cycle, END at cycle 66.
